// File: rtl/iserdes_align_ctrl.sv
// Word-alignment training controller for one ISERDESE2 lane: resets the deserialiser,
// then bitslips until the parallel word matches TRAIN_PATTERN for MATCH_COUNT cycles.
module iserdes_align_ctrl #(
    parameter int                    DATA_WIDTH        = 8,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN     = 8'hB4,
    parameter int                    SERDES_RST_CYCLES = 4,
    parameter int                    SETTLE_CYCLES     = 4,
    parameter int                    MATCH_COUNT       = 16,
    parameter int                    MAX_SLIPS         = 16
) (
    input  logic                               clk_div,
    input  logic                               RST,
    input  logic                               start_i,
    input  logic [DATA_WIDTH-1:0]              q_word_i,
    output logic                               iserdes_rst_o,
    output logic                               bitslip_o,
    output logic                               busy_o,
    output logic                               aligned_o,
    output logic                               fail_o,
    output logic [$clog2(MAX_SLIPS+1)-1:0]     slip_count_o
);

    localparam int SCW     = $clog2(MAX_SLIPS + 1);
    localparam int MCW     = $clog2(MATCH_COUNT + 1);
    localparam int TMR_LIM = (SERDES_RST_CYCLES > SETTLE_CYCLES) ? SERDES_RST_CYCLES : SETTLE_CYCLES;
    localparam int TCW     = $clog2(TMR_LIM + 1);

    localparam logic [TCW-1:0] RST_LAST    = TCW'(SERDES_RST_CYCLES - 1);
    localparam logic [TCW-1:0] SETTLE_LAST = TCW'(SETTLE_CYCLES - 1);
    localparam logic [MCW-1:0] MATCH_LAST  = MCW'(MATCH_COUNT - 1);
    localparam logic [MCW-1:0] MATCH_FULL  = MCW'(MATCH_COUNT);
    localparam logic [SCW-1:0] SLIP_LIMIT  = SCW'(MAX_SLIPS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRST,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    state_t         state_reg;
    logic [TCW-1:0] timer_reg;
    logic [MCW-1:0] match_reg;
    logic [SCW-1:0] slip_reg;
    logic           iserdes_rst_reg;
    logic           bitslip_reg;
    logic           busy_reg;
    logic           aligned_reg;
    logic           fail_reg;

    // Reset is asynchronous so the PHY is held in reset and BITSLIP released the instant RST rises.
    always_ff @(posedge clk_div or posedge RST) begin
        if (RST) begin
            state_reg       <= ST_IDLE;
            timer_reg       <= '0;
            match_reg       <= '0;
            slip_reg        <= '0;
            iserdes_rst_reg <= 1'b1;
            bitslip_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            aligned_reg     <= 1'b0;
            fail_reg        <= 1'b0;
        end else if (start_i) begin
            state_reg       <= ST_SRST;
            timer_reg       <= '0;
            match_reg       <= '0;
            slip_reg        <= '0;
            iserdes_rst_reg <= 1'b1;
            bitslip_reg     <= 1'b0;
            busy_reg        <= 1'b1;
            aligned_reg     <= 1'b0;
            fail_reg        <= 1'b0;
        end else begin
            bitslip_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    iserdes_rst_reg <= 1'b0;
                end
                ST_SRST: begin
                    if (timer_reg == RST_LAST) begin
                        state_reg       <= ST_SETTLE;
                        timer_reg       <= '0;
                        iserdes_rst_reg <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (timer_reg == SETTLE_LAST) begin
                        state_reg <= ST_CHECK;
                        timer_reg <= '0;
                        match_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (q_word_i == TRAIN_PATTERN) begin
                        if (match_reg == MATCH_LAST) begin
                            state_reg   <= ST_LOCKED;
                            match_reg   <= MATCH_FULL;
                            aligned_reg <= 1'b1;
                            busy_reg    <= 1'b0;
                        end else begin
                            match_reg <= match_reg + 1'b1;
                        end
                    end else if (slip_reg < SLIP_LIMIT) begin
                        // Any mismatch throws away the partial run; a fresh window follows the slip.
                        state_reg   <= ST_SLIP;
                        match_reg   <= '0;
                        slip_reg    <= slip_reg + 1'b1;
                        bitslip_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_FAIL;
                        match_reg <= '0;
                        fail_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_SLIP: begin
                    state_reg <= ST_SETTLE;
                    timer_reg <= '0;
                end
                ST_LOCKED, ST_FAIL: begin
                    state_reg <= state_reg;
                end
                default: begin
                    state_reg       <= ST_IDLE;
                    iserdes_rst_reg <= 1'b0;
                    busy_reg        <= 1'b0;
                end
            endcase
        end
    end

    assign iserdes_rst_o = iserdes_rst_reg;
    assign bitslip_o     = bitslip_reg;
    assign busy_o        = busy_reg;
    assign aligned_o     = aligned_reg;
    assign fail_o        = fail_reg;
    assign slip_count_o  = slip_reg;

endmodule

// File: tb/tb_iserdes_align_ctrl.sv
// Bench for iserdes_align_ctrl: a time-based training model (edges since start, next compare
// edge, slip tally) is checked against the DUT every cycle, plus literal timing expectations.
module tb_iserdes_align_ctrl;

    localparam int          DW  = 8;
    localparam logic [7:0]  PAT = 8'hB4;
    localparam int          R   = 4;
    localparam int          S   = 4;
    localparam int          M   = 16;
    localparam int          MS  = 16;
    localparam int          SCW = $clog2(MS + 1);

    localparam int MODE_CONST  = 0;
    localparam int MODE_SER    = 1;
    localparam int MODE_BROKEN = 2;
    localparam int MODE_RAND   = 3;

    logic           clk_div = 1'b0;
    logic           RST     = 1'b1;
    logic           start_i = 1'b0;
    logic [DW-1:0]  q_word_i = '0;
    logic           iserdes_rst_o;
    logic           bitslip_o;
    logic           busy_o;
    logic           aligned_o;
    logic           fail_o;
    logic [SCW-1:0] slip_count_o;

    iserdes_align_ctrl #(
        .DATA_WIDTH        (DW),
        .TRAIN_PATTERN     (PAT),
        .SERDES_RST_CYCLES (R),
        .SETTLE_CYCLES     (S),
        .MATCH_COUNT       (M),
        .MAX_SLIPS         (MS)
    ) dut (
        .clk_div       (clk_div),
        .RST           (RST),
        .start_i       (start_i),
        .q_word_i      (q_word_i),
        .iserdes_rst_o (iserdes_rst_o),
        .bitslip_o     (bitslip_o),
        .busy_o        (busy_o),
        .aligned_o     (aligned_o),
        .fail_o        (fail_o),
        .slip_count_o  (slip_count_o)
    );

    always #5 clk_div = ~clk_div;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Reference model: outputs expected after the most recent clock edge.
    bit m_started, m_active, m_rst, m_bitslip, m_busy, m_aligned, m_fail;
    int m_slips, m_n, m_next, m_run;

    // Stimulus environment.
    int         mode    = MODE_CONST;
    logic [7:0] q_const = 8'h00;
    int         ser_off = 0;
    int         cmp_idx = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_active = 0; m_rst = 1; m_bitslip = 0; m_busy = 0;
        m_aligned = 0; m_fail = 0; m_slips = 0; m_n = 0; m_next = 0; m_run = 0;
    endtask

    // m_n counts edges since the start edge; m_next is the edge of the next compare.
    task automatic model_step(input logic st, input logic [7:0] q);
        m_bitslip = 0;
        if (st) begin
            m_started = 1; m_active = 1; m_n = 0; m_slips = 0; m_run = 0;
            m_aligned = 0; m_fail = 0; m_rst = 1; m_busy = 1; m_next = R + S + 1;
            return;
        end
        if (!m_started) begin
            m_rst = 0;
            return;
        end
        if (!m_active) return;
        m_n++;
        m_rst = (m_n < R);
        if (m_n == m_next) begin
            if (q == PAT) begin
                m_run++;
                if (m_run == M) begin
                    m_aligned = 1; m_active = 0; m_busy = 0;
                end else begin
                    m_next = m_n + 1;
                end
            end else begin
                m_run = 0;
                if (m_slips < MS) begin
                    m_slips++; m_bitslip = 1; m_next = m_n + S + 2;
                end else begin
                    m_fail = 1; m_active = 0; m_busy = 0;
                end
            end
        end
    endtask

    task automatic get_q(output logic [7:0] q);
        logic [15:0] dbl;
        q = 8'($urandom);
        case (mode)
            MODE_CONST: q = q_const;
            MODE_SER: begin
                // Repeating serial pattern; each BITSLIP advances the word boundary by one bit.
                if (bitslip_o) ser_off = (ser_off + 1) % 8;
                dbl = {PAT, PAT};
                q = dbl[15 - ser_off -: 8];
            end
            MODE_BROKEN: begin
                if (m_active && (m_n + 1 == m_next)) begin
                    cmp_idx++;
                    q = (cmp_idx == 11) ? 8'h00 : PAT;
                end
            end
            MODE_RAND: begin
                if ($urandom_range(0, 7) != 0) q = PAT;
            end
            default: q = 8'h00;
        endcase
    endtask

    task automatic tick(input logic st);
        logic [7:0] q;
        @(negedge clk_div);
        RST = 1'b0;
        get_q(q);
        start_i  = st;
        q_word_i = q;
        @(posedge clk_div);
        cyc++;
        if (!RST) model_step(st, q);
    endtask

    task automatic run_train(input int e, input int budget, output int t_done,
                             output int n_rst, output int n_slip, output int bad_gaps);
        int last;
        n_rst = int'(m_rst); n_slip = 0; bad_gaps = 0; t_done = -1; last = -1;
        for (int i = 0; i < budget; i++) begin
            tick(1'b0);
            if (m_rst) n_rst++;
            if (m_bitslip) begin
                if (last >= 0 && (cyc - last) != S + 2) bad_gaps++;
                last = cyc;
                n_slip++;
            end
            if (!m_active) begin
                t_done = cyc - e;
                break;
            end
        end
    endtask

    always @(negedge clk_div) begin
        check("iserdes_rst_o", int'(iserdes_rst_o), int'(m_rst));
        check("bitslip_o",     int'(bitslip_o),     int'(m_bitslip));
        check("busy_o",        int'(busy_o),        int'(m_busy));
        check("aligned_o",     int'(aligned_o),     int'(m_aligned));
        check("fail_o",        int'(fail_o),        int'(m_fail));
        check("slip_count_o",  int'(slip_count_o),  m_slips);
    end

    initial begin
        int e, t_done, n_rst, n_slip, bad_gaps;
        bit found;
        model_reset();
        repeat (2) @(negedge clk_div);
        repeat (3) tick(1'b0);

        // Already aligned: 4 reset cycles, no slips, lock 24 edges after start.
        mode = MODE_CONST; q_const = PAT;
        tick(1'b1); e = cyc;
        run_train(e, 200, t_done, n_rst, n_slip, bad_gaps);
        check("aligned_time", t_done, 24);
        check("aligned_rst_cycles", n_rst, 4);
        check("aligned_slips", n_slip, 0);
        #1 check("aligned_dut_at_edge", int'(aligned_o), 1);
        repeat (3) tick(1'b0);

        // Word boundary three bits off: three slips spaced S+2, lock at 42.
        mode = MODE_SER; ser_off = 5;
        tick(1'b1); e = cyc;
        run_train(e, 300, t_done, n_rst, n_slip, bad_gaps);
        check("ser_time", t_done, 42);
        check("ser_slips", n_slip, 3);
        check("ser_gaps", bad_gaps, 0);
        #1 check("ser_slip_count", int'(slip_count_o), 3);

        // Restart from LOCKED.
        tick(1'b1);
        #1 check("restart_locked_aligned", int'(aligned_o), 0);
        check("restart_locked_rst", int'(iserdes_rst_o), 1);

        // Never matching: 16 slips then FAIL at 105.
        mode = MODE_CONST; q_const = 8'h00;
        e = cyc;
        run_train(e, 400, t_done, n_rst, n_slip, bad_gaps);
        check("fail_time", t_done, 105);
        check("fail_slips", n_slip, 16);
        #1 check("fail_dut_fail", int'(fail_o), 1);
        check("fail_dut_busy", int'(busy_o), 0);
        check("fail_dut_aligned", int'(aligned_o), 0);
        repeat (3) tick(1'b0);

        // Restart from FAIL into a broken match run (10 matches, 1 miss, then matches).
        mode = MODE_BROKEN; cmp_idx = 0;
        tick(1'b1); e = cyc;
        #1 check("restart_fail_fail", int'(fail_o), 0);
        check("restart_fail_slips", int'(slip_count_o), 0);
        run_train(e, 300, t_done, n_rst, n_slip, bad_gaps);
        check("broken_time", t_done, 40);
        check("broken_slips", n_slip, 1);

        // start_i coincident with the final match wins over locking.
        mode = MODE_CONST; q_const = PAT;
        tick(1'b1);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_active && m_run == M - 1 && m_n + 1 == m_next) begin
                found = 1;
                break;
            end
            tick(1'b0);
        end
        check("coincident_reached", int'(found), 1);
        tick(1'b1); e = cyc;
        #1 check("coincident_aligned", int'(aligned_o), 0);
        check("coincident_rst", int'(iserdes_rst_o), 1);
        check("coincident_busy", int'(busy_o), 1);
        run_train(e, 200, t_done, n_rst, n_slip, bad_gaps);
        check("coincident_time", t_done, 24);

        // Asynchronous reset while a bitslip pulse is on the wire.
        q_const = 8'h00;
        tick(1'b1);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0);
            if (m_bitslip) begin
                found = 1;
                break;
            end
        end
        check("bitslip_seen", int'(found), 1);
        #2 RST = 1'b1;
        #1 check("arst_iserdes_rst", int'(iserdes_rst_o), 1);
        check("arst_bitslip", int'(bitslip_o), 0);
        check("arst_busy", int'(busy_o), 0);
        check("arst_slips", int'(slip_count_o), 0);
        model_reset();
        tick(1'b0);
        #1 check("post_rst_idle", int'(iserdes_rst_o), 0);
        check("post_rst_busy", int'(busy_o), 0);

        // Randomised traffic with random restarts and resets.
        mode = MODE_RAND;
        tick(1'b1);
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 149) == 0));
            if ($urandom_range(0, 599) == 0) begin
                #2 RST = 1'b1;
                model_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
